// File: rtl/line_bridge_types.sv
// rtl/line_bridge_types.sv - shared state enum, line type and offset constants for cpu_line_bridge
package line_bridge_types;

  localparam int LINE_WORDS_DEF = 8;
  localparam int WORD_SEL_BITS  = $clog2(LINE_WORDS_DEF);
  localparam int OFFSET_BITS    = WORD_SEL_BITS + 2;

  typedef logic [32*LINE_WORDS_DEF-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MERGE,
    WRITEBACK,
    RESP
  } state_t;

endpackage

// File: rtl/line_word_merge.sv
// rtl/line_word_merge.sv - combinational byte-lane merge of a 32-bit word into one word of a line
module line_word_merge #(
  parameter int LINE_WORDS = 8
) (
  input  logic [32*LINE_WORDS-1:0]       line_in,
  input  logic [$clog2(LINE_WORDS)-1:0]  word_sel,
  input  logic [31:0]                    wdata,
  input  logic [3:0]                     byte_en,
  output logic [32*LINE_WORDS-1:0]       line_out
);

  always_comb begin
    line_out = line_in;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        line_out[{word_sel, 2'(i), 3'b000} +: 8] = wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/cpu_line_bridge.sv
// rtl/cpu_line_bridge.sv - 32-bit CPU word port to line-granular memory bridge (read / RMW write)
// Optional line-buffer hit path: CPU_LINE_BRIDGE_BUFFER_EN
module cpu_line_bridge
  import line_bridge_types::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [31:0]             mem_address,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_byte_enable,
  output logic [31:0]             mem_rdata,
  output logic                    mem_resp,
  output logic [31:0]             pmem_address,
  input  logic [32*LINE_WORDS-1:0] pmem_rdata,
  output logic [32*LINE_WORDS-1:0] pmem_wdata,
  output logic                    pmem_read,
  output logic                    pmem_write,
  input  logic                    pmem_resp
);

  localparam int WSEL = $clog2(LINE_WORDS);
  localparam int OFF  = WSEL + 2;
  localparam int LW   = 32 * LINE_WORDS;

  state_t            state_q, state_d;
  logic              op_write_q, op_write_d;
  logic [31:2]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [LW-1:0]     buf_q, buf_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              mem_resp_q, mem_resp_d;
  logic [31:0]       pmem_address_q, pmem_address_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [LW-1:0]     merged_line;
  logic [WSEL-1:0]   rsel;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^mem_address[1:0];

`ifdef CPU_LINE_BRIDGE_BUFFER_EN
  logic              valid_q, valid_d;
  logic [31:OFF]     tag_q, tag_d;
  logic              hit;

  assign hit = valid_q && (tag_q == mem_address[31:OFF]);
`endif

  line_word_merge #(.LINE_WORDS(LINE_WORDS)) u_merge (
    .line_in  (buf_q),
    .word_sel (addr_q[OFF-1:2]),
    .wdata    (wdata_q),
    .byte_en  (be_q),
    .line_out (merged_line)
  );

  always_comb begin
    state_d        = state_q;
    op_write_d     = op_write_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    buf_d          = buf_q;
    mem_rdata_d    = mem_rdata_q;
    pmem_address_d = pmem_address_q;
    rsel           = '0;
`ifdef CPU_LINE_BRIDGE_BUFFER_EN
    valid_d        = valid_q;
    tag_d          = tag_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (mem_write || mem_read) begin
          op_write_d     = mem_write;
          addr_d         = mem_address[31:2];
          wdata_d        = mem_wdata;
          be_d           = mem_byte_enable;
          pmem_address_d = {mem_address[31:OFF], {OFF{1'b0}}};
          state_d        = FETCH;
`ifdef CPU_LINE_BRIDGE_BUFFER_EN
          if (hit) state_d = mem_write ? MERGE : RESP;
`endif
        end
      end
      FETCH: begin
        if (pmem_resp) begin
          buf_d   = pmem_rdata;
          state_d = op_write_q ? MERGE : RESP;
`ifdef CPU_LINE_BRIDGE_BUFFER_EN
          valid_d = 1'b1;
          tag_d   = addr_q[31:OFF];
`endif
        end
      end
      MERGE: begin
        buf_d   = merged_line;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        if (pmem_resp) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they are glitch-free and stable while waiting.
    pmem_read_d  = (state_d == FETCH);
    pmem_write_d = (state_d == WRITEBACK);
    mem_resp_d   = (state_d == RESP);
    if (state_d == RESP) begin
      rsel        = addr_d[OFF-1:2];
      mem_rdata_d = buf_d[{rsel, 5'b00000} +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      op_write_q     <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      buf_q          <= '0;
      mem_rdata_q    <= '0;
      mem_resp_q     <= 1'b0;
      pmem_address_q <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
`ifdef CPU_LINE_BRIDGE_BUFFER_EN
      valid_q        <= 1'b0;
      tag_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      op_write_q     <= op_write_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      buf_q          <= buf_d;
      mem_rdata_q    <= mem_rdata_d;
      mem_resp_q     <= mem_resp_d;
      pmem_address_q <= pmem_address_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
`ifdef CPU_LINE_BRIDGE_BUFFER_EN
      valid_q        <= valid_d;
      tag_q          <= tag_d;
`endif
    end
  end

  assign mem_rdata    = mem_rdata_q;
  assign mem_resp     = mem_resp_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = buf_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;

endmodule

// File: doc/cpu_line_bridge.md
# cpu_line_bridge

Bridges the CPU datapath's 32-bit word memory port (MAR-aligned `mem_address`, `mem_wdata`, byte enables) to the 256-bit line-granular physical memory. Reads fetch a full line and return the addressed word. Writes perform a read-modify-write of the containing line. It sits directly downstream of the CPU datapath/controller pair and upstream of physical memory.

## Interface
Parameters:
- `LINE_WORDS`, default 8: 32-bit words per line. Must be a power of two. Line width is 32·`LINE_WORDS`; offset width is log2(`LINE_WORDS`)+2.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-low; state resets on a rising `clk` edge with `rst`=0.
- `mem_read` in 1: CPU read request, held until `mem_resp`.
- `mem_write` in 1: CPU write request, held until `mem_resp`.
- `mem_address` in 32: word address from MAR; bits [1:0] ignored.
- `mem_wdata` in 32: store data, already lane-aligned by the datapath.
- `mem_byte_enable` in 4: byte lanes to write.
- `mem_rdata` out 32: addressed word. Valid when `mem_resp`=1.
- `mem_resp` out 1: one-cycle completion pulse.
- `pmem_address` out 32: line address; offset bits are 0.
- `pmem_rdata` in 32·`LINE_WORDS`: line from memory.
- `pmem_wdata` out 32·`LINE_WORDS`: line to memory.
- `pmem_read` out 1: line read request, held until `pmem_resp`.
- `pmem_write` out 1: line write request, held until `pmem_resp`.
- `pmem_resp` in 1: memory completion pulse.

## Operation
States:
- **IDLE**
  - If `mem_write`: latch address, wdata and byte enables, set op=write, go to FETCH.
  - Else if `mem_read`: latch the same fields, set op=read, go to FETCH.
  - `mem_read` and `mem_write` asserted together are treated as a write.
- **FETCH**
  - `pmem_read`=1; `pmem_address` = latched address with offset bits cleared.
  - On `pmem_resp`, capture `pmem_rdata` into the line buffer.
  - Op=read goes to RESP; op=write goes to MERGE.
- **MERGE**
  - One cycle. For each lane i with byte_enable[i]=1, replace byte i of buffer word addr[offset-1:2] with the matching byte of the latched wdata.
  - Go to WRITEBACK.
- **WRITEBACK**
  - `pmem_write`=1; `pmem_wdata` = buffer; `pmem_address` as in FETCH.
  - On `pmem_resp`, go to RESP.
- **RESP**
  - `mem_resp`=1 for exactly one cycle; `mem_rdata` = buffer word addr[offset-1:2]. For writes this is the merged word.
  - Go to IDLE unconditionally. Requests present during RESP are ignored.

Rules:
- `pmem_read`/`pmem_write` are never asserted together. Both are registered outputs, stable for the whole wait.
- `mem_byte_enable`=0 on a write still performs the full RMW; the line is written back unchanged.
- `pmem_resp` outside FETCH/WRITEBACK is ignored.

## Timing
- Reset values:
  - state=IDLE.
  - `mem_resp`, `pmem_read`, `pmem_write` = 0.
  - `mem_rdata`, `pmem_address`, `pmem_wdata` = 0.
  - Line buffer cleared.
- Read latency: request sampled in IDLE at edge 0, FETCH begins at cycle 1. With `pmem_resp` in cycle k, `mem_resp` is asserted in cycle k+1. Minimum 2 cycles after the sampling edge.
- Write latency: FETCH wait, then 1 MERGE cycle, then WRITEBACK wait, then RESP.
- `mem_rdata` holds its last value after RESP until the next RESP.
- Reset mid-transaction: the next edge with `rst`=0 forces IDLE and drops `pmem_read`/`pmem_write`. The memory transaction is abandoned and no `mem_resp` is issued.
- The CPU deasserts its request the cycle after `mem_resp`. The bridge re-samples only in IDLE, so back-to-back requests incur no stale re-issue.

## Configuration
- `CPU_LINE_BRIDGE_BUFFER_EN` defined:
  - Keep a valid bit and tag for the line buffer; valid is cleared on reset.
  - Read in IDLE with valid=1 and tag match: go directly to RESP (1-cycle latency, no `pmem_read`).
  - Write hit: skip FETCH and go to MERGE. Write-through: WRITEBACK always occurs.
  - Any FETCH sets valid=1 and tag = latched line address.
- Not defined: no valid or tag state; every access performs FETCH.

## Structure
- Shared package `line_bridge_types` holds:
  - state enum (IDLE, FETCH, MERGE, WRITEBACK, RESP);
  - `line_t` typedef;
  - `OFFSET_BITS` and `WORD_SEL_BITS` constants.
- One sub-module, `line_word_merge`: combinational byte-lane merge of a 32-bit word into a selected word of a line.

## Test plan
- Read: address 0x0000_0044, memory line with word1=0xDEAD_BEEF, `pmem_resp` after 3 cycles.
  - `pmem_address`=0x0000_0040.
  - `mem_rdata`=0xDEAD_BEEF with one `mem_resp` pulse.
  - `pmem_write` never asserted.
- Byte write: address 0x0000_0048, wdata 0x00AB_0000, byte enables 4'b0100, old word2=0x1122_3344.
  - Written-back line word2=0x11AB_3344; all other words unchanged.
  - `mem_resp` one cycle after the writeback `pmem_resp`.
- Simultaneous `mem_read`=`mem_write`=1: treated as a write, shown by `pmem_write` asserting after FETCH.
- Reset (`rst`=0) during WRITEBACK wait:
  - next cycle `pmem_write`=0 and state=IDLE;
  - no `mem_resp`;
  - a following read completes normally.
- With `CPU_LINE_BRIDGE_BUFFER_EN`: read 0x100, then read 0x104.
  - The second read gives `mem_resp` the cycle after sampling with `pmem_read`=0.
  - After reset, the same read refetches.
- Stray `pmem_resp` pulse in IDLE: no state change and no `mem_resp`.
